busif_ncs: RTL
==============

Name: busif_ncs

Overview:
- Parametrised I/O bus interface for the MicroBlaze MCS IO bus.
- Decodes IO_Address[31:24] into NBANK consecutive banks starting at BANK_BASE and drives one-hot write and read strobes.
- Each bank completes either with a fixed single wait cycle or by a per-bank slave-ready handshake, selected per bank by a parameter.
- Adds a timeout watchdog and an error response for unmapped banks, both of which report through a sticky error flag.

Parameters:
NBANK, 8, number of banks (1..16)
BANK_BASE, 8'hC0, bank code of bank 0; bank i = BANK_BASE+i
HS_MASK, 8'h01, bit i=1: bank i completes on SRDY[i]; bit i=0: fixed 1-cycle completion
TO_CYCLES, 255, handshake timeout in cycles (0 = timeout disabled)
ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
IO_Address  in  32  MCS I/O address; [31:24] = bank code
IO_Addr_Strobe  in  1  address valid, one cycle
IO_Read_Strobe  in  1  read request, qualifies IO_Addr_Strobe
IO_Write_Strobe  in  1  write request, qualifies IO_Addr_Strobe
IO_Read_Data  out  32  registered read data
IO_Ready  out  1  one-cycle completion pulse
WR  out  NBANK  one-hot write strobe
RD  out  NBANK  one-hot read strobe
RDATA  in  32*NBANK  bank i read data at [32*i+31:32*i]
SRDY  in  NBANK  per-bank slave ready, used only where HS_MASK[i]=1
ERR_CLR  in  1  clears BUS_ERR
BUS_ERR  out  1  sticky error flag
ERR_ADDR  out  32  address of the most recent errored access

Behaviour:
- Reset (async, RST=1): state=IDLE; IO_Ready=0; IO_Read_Data=0; BUS_ERR=0; ERR_ADDR=0; timeout counter=0.
- WR and RD drop to 0 combinationally while RST=1.
- Accept: in IDLE, an access is accepted in cycle T when IO_Addr_Strobe & (IO_Read_Strobe | IO_Write_Strobe).
- On accept, latch bank index = IO_Address[31:24]-BANK_BASE, the direction, and the full address.
- In range means bank code in [BANK_BASE, BANK_BASE+NBANK-1]; compare with 9-bit arithmetic so there is no wrap past 8'hFF.
- WR/RD: combinational one-hot pulse in cycle T only, from IO_Address and the strobes, and only in IDLE.
- Out-of-range accesses produce all zeros on WR/RD.
- If both read and write strobes are high, write wins: WR pulses, RD stays 0, and the access is treated as a write.
- States: IDLE, WAIT, RESP.
- IDLE -> RESP in these cases:
  - accepted, fixed bank (HS_MASK[i]=0);
  - accepted, handshake bank with SRDY[i]=1 in cycle T;
  - accepted, out of range.
- IDLE -> WAIT when accepted, handshake bank, SRDY[i]=0 in T. The counter loads 1.
- WAIT -> RESP when either:
  - SRDY[i]=1, normal completion; or
  - TO_CYCLES!=0 and counter==TO_CYCLES, timeout.
- Otherwise WAIT holds and the counter increments, saturating at TO_CYCLES.
- SRDY takes priority over timeout in the same cycle.
- RESP -> IDLE unconditionally.
- IO_Ready=1 exactly in RESP, so it is a single-cycle pulse.
- Latencies:
  - Fixed or out-of-range bank: IO_Ready at T+1.
  - Handshake bank: SRDY first high in cycle S (S>=T) gives IO_Ready at S+1.
  - Timeout: IO_Ready at T+TO_CYCLES+1.
- Read data:
  - On the transition into RESP for a read, IO_Read_Data <= RDATA[bank], or ERR_DATA on error.
  - IO_Read_Data holds until the next read completes.
  - Writes do not change IO_Read_Data.
- Errors (out of range or timeout): BUS_ERR <= 1 and ERR_ADDR <= latched address, both registered on entry to RESP.
- ERR_CLR clears BUS_ERR. If ERR_CLR and a new error occur in the same cycle, the error wins and BUS_ERR stays 1.
- Strobes received in WAIT or RESP are ignored: no WR/RD, no state change. The MCS never issues them.
- SRDY for banks other than the latched one, and SRDY for fixed banks, are ignored.
- If reset is asserted mid-WAIT, the FSM returns to IDLE immediately with no IO_Ready pulse.

Decomposition:
- Package busif_pkg: state enum (IDLE/WAIT/RESP), BANK_W=8, DATA_W=32, default ERR_DATA.
- Sub-module busif_decode: combinational bank-code range check, bank index, and one-hot WR/RD generation.
- The FSM, counter and data/error registers stay in busif_ncs.

Test Plan:
- Write to 8'hC3 (HS_MASK[3]=0) at T -> WR=8'b00001000 in T only; IO_Ready at T+1; IO_Read_Data unchanged.
- Read 8'hC0 (handshake) with SRDY[0] raised at T+4, RDATA0=32'h1234_5678 -> RD[0] pulse at T; IO_Ready at T+5; IO_Read_Data=32'h1234_5678.
- Read 8'hC0 with SRDY[0] never raised, TO_CYCLES=4 -> IO_Ready at T+5; IO_Read_Data=32'hDEAD_BEEF; BUS_ERR=1; ERR_ADDR=32'hC000_0010 (the address issued).
- Read 8'hC8 (NBANK=8) -> WR=RD=0; IO_Ready at T+1; data ERR_DATA; BUS_ERR=1. Then ERR_CLR pulse -> BUS_ERR=0 next cycle.
- Read 8'hC0 waiting, RST asserted at T+2 -> state IDLE and IO_Ready=0 immediately. After release, a read to 8'hC1 completes at T'+1.
- SRDY[0] and timeout coincide (SRDY at cycle T+TO_CYCLES) -> normal data returned, BUS_ERR stays 0.

Source files
------------

// File: rtl/busif_pkg.sv
// Shared widths, FSM state encoding and defaults for the MCS IO bus interface.
// Other files pull these in with import busif_pkg::*.
package busif_pkg;

    localparam int unsigned BANK_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/busif_decode.sv
// Bank-code decode: range check, bank offset and one-hot WR/RD strobes.
// Purely combinational; strobes only fire while enable is high.
module busif_decode
    import busif_pkg::*;
#(
    parameter int unsigned       NBANK     = 8,
    parameter logic [BANK_W-1:0] BANK_BASE = 8'hC0
) (
    input  logic [BANK_W-1:0] code,
    input  logic              enable,
    input  logic              addr_strobe,
    input  logic              read_strobe,
    input  logic              write_strobe,
    output logic              accept,
    output logic              in_range,
    output logic              is_write,
    output logic [BANK_W-1:0] offset,
    output logic [NBANK-1:0]  wr,
    output logic [NBANK-1:0]  rd
);

    // One extra bit so BANK_BASE+NBANK past 8'hFF cannot wrap around.
    localparam logic [BANK_W:0] LO = {1'b0, BANK_BASE};
    localparam logic [BANK_W:0] HI = LO + (BANK_W + 1)'(NBANK);

    logic [BANK_W:0] code_ext;

    assign code_ext = {1'b0, code};
    assign in_range = (code_ext >= LO) && (code_ext < HI);
    assign offset   = code - BANK_BASE;
    assign accept   = enable & addr_strobe & (read_strobe | write_strobe);
    assign is_write = write_strobe;

    always_comb begin
        wr = '0;
        rd = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (accept && in_range && (offset == BANK_W'(i))) begin
                wr[i] = is_write;
                rd[i] = ~is_write;
            end
        end
    end

endmodule

// File: rtl/busif_ncs.sv
// MicroBlaze MCS IO bus interface: bank decode, fixed or handshake completion,
// timeout watchdog and sticky error reporting.
module busif_ncs
    import busif_pkg::*;
#(
    parameter int unsigned       NBANK     = 8,
    parameter logic [BANK_W-1:0] BANK_BASE = 8'hC0,
    parameter logic [15:0]       HS_MASK   = 16'h0001,
    parameter int unsigned       TO_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA  = DEFAULT_ERR_DATA
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [31:0]             IO_Address,
    input  logic                    IO_Addr_Strobe,
    input  logic                    IO_Read_Strobe,
    input  logic                    IO_Write_Strobe,
    output logic [DATA_W-1:0]       IO_Read_Data,
    output logic                    IO_Ready,
    output logic [NBANK-1:0]        WR,
    output logic [NBANK-1:0]        RD,
    input  logic [DATA_W*NBANK-1:0] RDATA,
    input  logic [NBANK-1:0]        SRDY,
    input  logic                    ERR_CLR,
    output logic                    BUS_ERR,
    output logic [31:0]             ERR_ADDR
);

    localparam int unsigned      CNT_W   = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYCLES);
    localparam bit               TO_EN   = (TO_CYCLES != 0);

    state_t              state_q, state_d;
    logic [BANK_W-1:0]   bank_q;
    logic                write_q;
    logic [31:0]         addr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                bus_err_q;
    logic [31:0]         err_addr_q;

    logic                idle;
    logic                dec_accept;
    logic                dec_in_range;
    logic                dec_is_write;
    logic [BANK_W-1:0]   dec_offset;

    logic [BANK_W-1:0]   sel_idx;
    logic                sel_hs;
    logic                sel_srdy;
    logic [DATA_W-1:0]   sel_rdata;

    logic                done;
    logic                err;
    logic                cur_write;
    logic [31:0]         cur_addr;

    assign idle = (state_q == ST_IDLE);

    busif_decode #(
        .NBANK     (NBANK),
        .BANK_BASE (BANK_BASE)
    ) u_decode (
        .code         (IO_Address[31:24]),
        .enable       (idle & ~RST),
        .addr_strobe  (IO_Addr_Strobe),
        .read_strobe  (IO_Read_Strobe),
        .write_strobe (IO_Write_Strobe),
        .accept       (dec_accept),
        .in_range     (dec_in_range),
        .is_write     (dec_is_write),
        .offset       (dec_offset),
        .wr           (WR),
        .rd           (RD)
    );

    // In IDLE the live decode selects the bank; afterwards the latched one does.
    always_comb begin
        sel_idx   = idle ? dec_offset : bank_q;
        sel_hs    = 1'b0;
        sel_srdy  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (sel_idx == BANK_W'(i)) begin
                sel_hs    = HS_MASK[i];
                sel_srdy  = SRDY[i];
                sel_rdata = RDATA[DATA_W*i +: DATA_W];
            end
        end
    end

    assign cur_write = idle ? dec_is_write : write_q;
    assign cur_addr  = idle ? IO_Address : addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dec_accept) begin
                    if (!dec_in_range) begin
                        state_d = ST_RESP;
                        done    = 1'b1;
                        err     = 1'b1;
                    end else if (!sel_hs || sel_srdy) begin
                        state_d = ST_RESP;
                        done    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // Slave ready beats the watchdog when both land in one cycle.
                if (sel_srdy) begin
                    state_d = ST_RESP;
                    done    = 1'b1;
                end else if (TO_EN && (cnt_q == CNT_MAX)) begin
                    state_d = ST_RESP;
                    done    = 1'b1;
                    err     = 1'b1;
                end else if (TO_EN && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bank_q     <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (dec_accept) begin
                bank_q  <= dec_offset;
                write_q <= dec_is_write;
                addr_q  <= IO_Address;
            end
            if (done && !cur_write) begin
                rdata_q <= err ? ERR_DATA : sel_rdata;
            end
            if (err) begin
                bus_err_q  <= 1'b1;
                err_addr_q <= cur_addr;
            end else if (ERR_CLR) begin
                bus_err_q <= 1'b0;
            end
        end
    end

    assign IO_Ready     = (state_q == ST_RESP);
    assign IO_Read_Data = rdata_q;
    assign BUS_ERR      = bus_err_q;
    assign ERR_ADDR     = err_addr_q;

endmodule
